// File: rtl/adc_frame_align_ctrl.sv
// -----------------------------------------------------------------------------
// adc_frame_align_ctrl
//
// Frame-alignment sequencer for the ADC LVDS receive path, clocked by the
// divided SERDES clock. It compares the deserialised frame-clock word against
// the expected frame pattern. Until the pattern is seen for LockCount
// consecutive cycles, it issues single-cycle bitslip pulses, each followed by
// a settle interval. Once locked it keeps watching the word. A run of
// LossCount consecutive mismatches counts as a loss of lock and starts a new
// alignment attempt automatically.
//
// Ports
//   AlnClkDiv     in   divided SERDES clock (only clock)
//   AlnRst_n      in   asynchronous active-low reset
//   AlnEna        in   level, high enables alignment (MMCM locked)
//   AlnReSync     in   single-cycle request to restart alignment
//   AlnFrmWord    in   deserialised frame-clock word [15:0]
//   AlnBitslip    out  single-cycle bitslip pulse to all deserialisers
//   AlnAlignDone  out  high while locked
//   AlnAlignFail  out  sticky, set after MaxSlips slips without lock
//   AlnSlipCnt    out  bitslips issued in the current attempt [4:0]
//   AlnLossCnt    out  loss-of-lock events since reset, saturating [7:0]
// -----------------------------------------------------------------------------
module adc_frame_align_ctrl #(
  parameter int unsigned AdcBits      = 14,
  parameter logic [15:0] FrmPattern   = 16'b0011111110000000,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned MaxSlips     = 16,
  parameter int unsigned LockCount    = 8,
  parameter int unsigned LossCount    = 3
) (
  input  logic        AlnClkDiv,
  input  logic        AlnRst_n,
  input  logic        AlnEna,
  input  logic        AlnReSync,
  input  logic [15:0] AlnFrmWord,
  output logic        AlnBitslip,
  output logic        AlnAlignDone,
  output logic        AlnAlignFail,
  output logic [4:0]  AlnSlipCnt,
  output logic [7:0]  AlnLossCnt
);

  localparam logic [3:0] SettleLd = 4'(SettleCycles);
  localparam logic [4:0] SlipMax  = 5'(MaxSlips);
  localparam logic [3:0] LockTgt  = 4'(LockCount);
  localparam logic [3:0] LossTgt  = 4'(LossCount);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCheck,
    StSlip,
    StLocked,
    StFail
  } alnState_t;

  alnState_t  state, stateNxt;
  logic [3:0] settleCnt, settleNxt;
  logic [3:0] matchCnt, matchNxt;
  logic [3:0] missCnt, missNxt;
  logic [4:0] slipCnt, slipNxt;
  logic [7:0] lossCnt, lossNxt;
  logic       bitslipQ, bitslipNxt;
  logic       doneQ, doneNxt;
  logic       failQ, failNxt;
  logic       isMatch;

  assign isMatch = (AlnFrmWord[AdcBits-1:0] == FrmPattern[AdcBits-1:0]);

  // State and all output registers.
  always_ff @(posedge AlnClkDiv or negedge AlnRst_n) begin
    if (!AlnRst_n) begin
      state     <= StIdle;
      settleCnt <= '0;
      matchCnt  <= '0;
      missCnt   <= '0;
      slipCnt   <= '0;
      lossCnt   <= '0;
      bitslipQ  <= 1'b0;
      doneQ     <= 1'b0;
      failQ     <= 1'b0;
    end else begin
      state     <= stateNxt;
      settleCnt <= settleNxt;
      matchCnt  <= matchNxt;
      missCnt   <= missNxt;
      slipCnt   <= slipNxt;
      lossCnt   <= lossNxt;
      bitslipQ  <= bitslipNxt;
      doneQ     <= doneNxt;
      failQ     <= failNxt;
    end
  end

  // Next-state logic. The flag outputs are computed from the state being
  // entered. Registering them gives single-cycle bitslip pulses aligned with
  // the SLIP state, and done/fail levels aligned with LOCKED/FAIL.
  always_comb begin
    stateNxt   = state;
    settleNxt  = settleCnt;
    matchNxt   = matchCnt;
    missNxt    = missCnt;
    slipNxt    = slipCnt;
    lossNxt    = lossCnt;
    bitslipNxt = 1'b0;
    doneNxt    = 1'b0;
    failNxt    = 1'b0;

    if (!AlnEna) begin
      stateNxt  = StIdle;
      settleNxt = '0;
      matchNxt  = '0;
      missNxt   = '0;
      slipNxt   = '0;
    end else if (AlnReSync && (state != StIdle)) begin
      stateNxt  = StSettle;
      settleNxt = SettleLd;
      matchNxt  = '0;
      missNxt   = '0;
      slipNxt   = '0;
    end else begin
      unique case (state)
        StIdle: begin
          stateNxt  = StSettle;
          settleNxt = SettleLd;
        end

        StSettle: begin
          if (settleCnt <= 4'd1) begin
            stateNxt  = StCheck;
            settleNxt = '0;
            matchNxt  = '0;
          end else begin
            settleNxt = settleCnt - 4'd1;
          end
        end

        StCheck: begin
          if (isMatch) begin
            if ((matchCnt + 4'd1) == LockTgt) begin
              stateNxt = StLocked;
              matchNxt = '0;
              missNxt  = '0;
              doneNxt  = 1'b1;
            end else begin
              matchNxt = matchCnt + 4'd1;
            end
          end else begin
            matchNxt = '0;
            if (slipCnt == SlipMax) begin
              stateNxt = StFail;
              failNxt  = 1'b1;
            end else begin
              stateNxt   = StSlip;
              bitslipNxt = 1'b1;
              slipNxt    = slipCnt + 5'd1;
            end
          end
        end

        StSlip: begin
          stateNxt  = StSettle;
          settleNxt = SettleLd;
        end

        StLocked: begin
          doneNxt = 1'b1;
          if (isMatch) begin
            missNxt = '0;
          end else if ((missCnt + 4'd1) == LossTgt) begin
            // Lost lock: start a fresh attempt with a full settle interval.
            stateNxt  = StSettle;
            settleNxt = SettleLd;
            missNxt   = '0;
            slipNxt   = '0;
            doneNxt   = 1'b0;
            if (lossCnt != 8'hFF) begin
              lossNxt = lossCnt + 8'd1;
            end
          end else begin
            missNxt = missCnt + 4'd1;
          end
        end

        StFail: begin
          failNxt = 1'b1;
        end

        default: begin
          stateNxt = StIdle;
        end
      endcase
    end
  end

  assign AlnBitslip   = bitslipQ;
  assign AlnAlignDone = doneQ;
  assign AlnAlignFail = failQ;
  assign AlnSlipCnt   = slipCnt;
  assign AlnLossCnt   = lossCnt;

endmodule

// File: tb/tb_adc_frame_align_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_frame_align_ctrl
//
// Bench for adc_frame_align_ctrl. Each scenario pushes the events it expects
// (bitslip pulses, done rise/fall, fail rise) with their cycle numbers. A
// negedge monitor pops and compares them as the DUT produces them. Cycle 0 is
// the edge at which AlnEna is first sampled high. The label printed for an
// observation is the cycle whose value is being looked at.
// -----------------------------------------------------------------------------
module tb_adc_frame_align_ctrl;

  localparam logic [15:0] Pat = 16'b0011111110000000;

  localparam int EvSlip     = 0;
  localparam int EvDoneRise = 1;
  localparam int EvDoneFall = 2;
  localparam int EvFailRise = 3;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        ena = 1'b0;
  logic        reSync = 1'b0;
  logic [15:0] frmWord = Pat;
  logic        bitslip;
  logic        alignDone;
  logic        alignFail;
  logic [4:0]  slipCnt;
  logic [7:0]  lossCnt;

  adc_frame_align_ctrl #(
    .AdcBits      (14),
    .FrmPattern   (Pat),
    .SettleCycles (4),
    .MaxSlips     (16),
    .LockCount    (8),
    .LossCount    (3)
  ) dut (
    .AlnClkDiv    (clk),
    .AlnRst_n     (rstN),
    .AlnEna       (ena),
    .AlnReSync    (reSync),
    .AlnFrmWord   (frmWord),
    .AlnBitslip   (bitslip),
    .AlnAlignDone (alignDone),
    .AlnAlignFail (alignFail),
    .AlnSlipCnt   (slipCnt),
    .AlnLossCnt   (lossCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
  } evT;

  evT   evQ[$];
  int   nTests = 0;
  int   nFail = 0;
  int   edgeN = 0;
  int   t0 = 0;
  bit   track = 1'b0;
  int   mode = 0;
  int   off = 0;
  bit   missMask[0:255];
  logic prevDone = 1'b0;
  logic prevFail = 1'b0;

  always @(posedge clk) edgeN <= edgeN + 1;

  task automatic chkVal(input string tag, input int got, input int exp);
    nTests++;
    if (got != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, edgeN - t0);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] w, input int n);
    logic [15:0] r;
    r = w;
    for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
    return r;
  endfunction

  task automatic pushEv(input int kind, input int cyc);
    evT e;
    e.kind = kind;
    e.cyc  = cyc;
    evQ.push_back(e);
  endtask

  task automatic gotEv(input int kind, input int cyc);
    evT e;
    if (evQ.size() == 0) begin
      chkVal("evUnexpected", kind, -1);
    end else begin
      e = evQ.pop_front();
      chkVal("evKind", kind, e.kind);
      chkVal("evCycle", cyc, e.cyc);
    end
  endtask

  // Monitor plus frame-word source. The rotating source models a deserialiser
  // whose word moves one bit closer to the pattern on every bitslip pulse.
  always @(negedge clk) begin
    int l;
    l = edgeN - t0;
    if (track) begin
      if (bitslip) gotEv(EvSlip, l);
      if (alignDone && !prevDone) gotEv(EvDoneRise, l);
      if (!alignDone && prevDone) gotEv(EvDoneFall, l);
      if (alignFail && !prevFail) gotEv(EvFailRise, l);
    end
    prevDone = alignDone;
    prevFail = alignFail;
    if (mode == 1 && bitslip && off > 0) off--;
    case (mode)
      0:       frmWord = Pat;
      1:       frmWord = rotl(Pat, off);
      2:       frmWord = 16'h0000;
      default: frmWord = (l >= 0 && l < 256 && missMask[l]) ? 16'h0000 : Pat;
    endcase
  end

  task automatic waitLbl(input int lbl);
    while ((edgeN - t0) < lbl) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic startScen(input int m, input int rotOff);
    track = 1'b0;
    ena   = 1'b0;
    idleCycles(3);
    evQ.delete();
    for (int i = 0; i < 256; i++) missMask[i] = 1'b0;
    mode = m;
    off  = rotOff;
    ena  = 1'b1;
    t0   = edgeN;
    track = 1'b1;
  endtask

  task automatic endScen();
    chkVal("queueEmpty", evQ.size(), 0);
    track = 1'b0;
    ena   = 1'b0;
  endtask

  initial begin
    idleCycles(2);
    chkVal("rstBitslip", int'(bitslip), 0);
    chkVal("rstDone", int'(alignDone), 0);
    chkVal("rstFail", int'(alignFail), 0);
    chkVal("rstSlipCnt", int'(slipCnt), 0);
    chkVal("rstLossCnt", int'(lossCnt), 0);
    rstN = 1'b1;
    idleCycles(2);

    // Word already aligned: no slips, done rises at cycle 13.
    startScen(0, 0);
    pushEv(EvDoneRise, 13);
    waitLbl(12);
    chkVal("alignedDoneEarly", int'(alignDone), 0);
    waitLbl(20);
    chkVal("alignedDone", int'(alignDone), 1);
    chkVal("alignedSlipCnt", int'(slipCnt), 0);
    endScen();

    // Three slips needed: pulses at 6, 12, 18; done at 31.
    startScen(1, 3);
    pushEv(EvSlip, 6);
    pushEv(EvSlip, 12);
    pushEv(EvSlip, 18);
    pushEv(EvDoneRise, 31);
    waitLbl(40);
    chkVal("rotSlipCnt", int'(slipCnt), 3);
    chkVal("rotDone", int'(alignDone), 1);
    endScen();

    // Never matches: 16 slips, fail after the CHECK at cycle 101.
    startScen(2, 0);
    for (int j = 1; j <= 16; j++) pushEv(EvSlip, 6 * j);
    pushEv(EvFailRise, 102);
    waitLbl(110);
    chkVal("failFlag", int'(alignFail), 1);
    chkVal("failSlipCnt", int'(slipCnt), 16);
    chkVal("failDone", int'(alignDone), 0);
    chkVal("queueEmpty", evQ.size(), 0);
    track  = 1'b0;
    reSync = 1'b1;
    idleCycles(1);
    reSync = 1'b0;
    ena    = 1'b0;
    chkVal("resyncFail", int'(alignFail), 0);
    chkVal("resyncSlipCnt", int'(slipCnt), 0);
    endScen();

    // Loss of lock: 2 misses, 1 match, 3 misses -> loss, then re-lock.
    startScen(3, 0);
    missMask[15] = 1'b1;
    missMask[16] = 1'b1;
    missMask[18] = 1'b1;
    missMask[19] = 1'b1;
    missMask[20] = 1'b1;
    pushEv(EvDoneRise, 13);
    pushEv(EvDoneFall, 21);
    pushEv(EvDoneRise, 33);
    waitLbl(18);
    chkVal("lossDoneHold", int'(alignDone), 1);
    waitLbl(21);
    chkVal("lossDoneFall", int'(alignDone), 0);
    chkVal("lossCnt", int'(lossCnt), 1);
    chkVal("lossSlipCnt", int'(slipCnt), 0);
    waitLbl(40);
    chkVal("relockDone", int'(alignDone), 1);
    endScen();

    // Partial run: 5 matches then a miss -> slip at 11, lock at 24.
    startScen(3, 0);
    missMask[10] = 1'b1;
    pushEv(EvSlip, 11);
    pushEv(EvDoneRise, 24);
    waitLbl(12);
    chkVal("partialSlipCnt", int'(slipCnt), 1);
    waitLbl(20);
    chkVal("partialDone", int'(alignDone), 0);
    waitLbl(26);
    chkVal("partialLocked", int'(alignDone), 1);
    endScen();

    // Ena low and ReSync together mid-SETTLE: ena wins, IDLE next cycle.
    startScen(0, 0);
    waitLbl(2);
    track  = 1'b0;
    ena    = 1'b0;
    reSync = 1'b1;
    idleCycles(1);
    reSync = 1'b0;
    chkVal("enaLowBitslip", int'(bitslip), 0);
    chkVal("enaLowDone", int'(alignDone), 0);
    chkVal("enaLowFail", int'(alignFail), 0);
    chkVal("enaLowSlipCnt", int'(slipCnt), 0);
    chkVal("enaLowLossCnt", int'(lossCnt), 1);
    // Restarting from IDLE must take the full settle + lock time.
    evQ.delete();
    ena   = 1'b1;
    t0    = edgeN;
    track = 1'b1;
    pushEv(EvDoneRise, 13);
    waitLbl(16);
    endScen();

    // Reset asserted during SLIP drops everything asynchronously.
    startScen(2, 0);
    pushEv(EvSlip, 6);
    waitLbl(6);
    chkVal("slipBeforeRst", int'(bitslip), 1);
    rstN = 1'b0;
    #1;
    chkVal("rstMidBitslip", int'(bitslip), 0);
    chkVal("rstMidSlipCnt", int'(slipCnt), 0);
    chkVal("rstMidLossCnt", int'(lossCnt), 0);
    chkVal("rstMidDone", int'(alignDone), 0);
    chkVal("rstMidFail", int'(alignFail), 0);
    endScen();
    idleCycles(2);
    rstN = 1'b1;
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
